fwd_pass_sched: RTL and testbench
=================================

# fwd_pass_sched

Forward-pass scheduler for the 4-input / 8-hidden / 1-output network. It replaces eight parallel hidden-neuron multipliers and the output-neuron multiplier tree with one time-shared multiply-accumulate unit. It sequences weight reads from a synchronous weight ROM, accumulates each neuron's dot product, and stores the hidden activations locally. It then runs the output neuron over them and presents the result to the top level, which drives `final_o[7:0]` onto `uo_out`.

## Interface
Parameters:
- `N_IN`, 4, inputs per hidden neuron
- `N_HID`, 8, hidden neurons (= output-neuron inputs)
- `X_W`, 4, input element width (unsigned)
- `W_W`, 4, weight width (unsigned)
- `H_W`, 10, hidden activation width
- `F_W`, 18, final output width

Ports:
- `clk_i`  in  1  single clock
- `rst_i`  in  1  synchronous, active-high reset
- `start_i`  in  1  request a forward pass; honoured only in IDLE
- `x_i`  in  N_IN*X_W  input vector, element i at `[i*X_W +: X_W]`; captured on the accepting edge
- `w_rd_o`  out  1  weight ROM read strobe
- `w_addr_o`  out  6  weight ROM address
- `w_data_i`  in  W_W  ROM data, valid one cycle after `w_rd_o`/`w_addr_o`
- `busy_o`  out  1  pass in progress
- `done_o`  out  1  one-cycle pulse when `final_o` updates
- `final_o`  out  F_W  output-neuron result, held until the next update

## Operation
- Weight map:
  - hidden neuron k, input i at address k*4+i (0..31)
  - output weight j at address 32+j (32..39)
- States:
  - IDLE: `start_i`=1 latches `x_i`, clears the term counter, and moves to HID.
  - HID: issues addresses 0..31, one per cycle. After address 31 it moves to OUT.
  - OUT: issues addresses 32..39. After 39 it moves to DRAIN.
  - DRAIN: waits for the last product, then returns to IDLE.
- Each cycle in HID/OUT: `w_rd_o`=1, and `w_addr_o` = the term counter.
- Pipeline tag: a one-stage delayed tag (valid, phase, term index) travels with each read.
- When a tagged term returns:
  - product = operand × `w_data_i`
  - operand = x[i] in the hidden phase, h[j] in the output phase
  - on the first term of a neuron the accumulator loads the product; on other terms it adds the product
- Last term of hidden neuron k: h[k] ← acc + product. No saturation is needed: the maximum is 4·15·15 = 900 < 2^10.
- Last output term: `final_o` ← acc + product and `done_o` pulses. The maximum is 8·1023·15 < 2^18.
- Hidden neurons and the output neuron run back-to-back with no bubble. h[7] is written before it is first read.
- `start_i` while busy is ignored and not queued. `x_i` changes after acceptance have no effect.
- `rst_i` at any time, including mid-pass:
  - state → IDLE
  - accumulator, h[], pipeline tag, `final_o` → 0
  - `done_o`, `busy_o`, `w_rd_o` → 0
  - `w_addr_o` → 0
  - no `done_o` is produced for the aborted pass

## Timing
- Reset values: `busy_o`=0, `done_o`=0, `w_rd_o`=0, `w_addr_o`=0, `final_o`=0.
- Accepting edge = E0.
- `w_rd_o`=1 for the 40 cycles following E0..E39, with addresses 0..39 in order.
- Products accumulate at E2..E41.
- h[k] is written at E(5+4k).
- `final_o` updates and `done_o` rises at E41; `done_o` falls at E42.
- `busy_o` is high after E0 through E40 and low after E41.
- A `start_i` high at E41 is ignored because the state is not yet IDLE. The earliest re-accept is E42, so the back-to-back period is 42 cycles.
- `start_i` and `rst_i` asserted at the same edge: reset wins.

## Structure
- Shared package `nn_pkg` holds:
  - `N_IN`, `N_HID`, `X_W`, `W_W`, `H_W`, `F_W`
  - `HID_BASE`=0, `OUT_BASE`=32, `LAST_ADDR`=39
  - state enum {IDLE, HID, OUT, DRAIN}
- Sub-module `mac_unit` contains:
  - a W_W × H_W multiplier
  - an F_W accumulator with a load-vs-add control
  - a registered result
- The scheduler keeps the FSM, term counter, tag pipeline, x latch and h[] register file.

## Test plan
- ROM all 1, x = (1,2,3,4) → every h = 10, `final_o` = 80, `done_o` exactly at E41.
- ROM all 15, x all 15 → h = 900, `final_o` = 108000, no overflow.
- ROM holding distinct values, any x → `w_addr_o` steps 0..39 once each with `w_rd_o` high exactly 40 cycles, and `final_o` matches the golden-model dot products.
- `start_i` held high → accepts at E0, E42, E84; one `done_o` per pass; `busy_o` low exactly one cycle between passes.
- `start_i` pulsed at E10 and `x_i` changed at E5 → the pulse is ignored and the result is unchanged from the E0 capture.
- `rst_i` at E20, then start → all outputs 0 and no `done_o` for the aborted pass; the new pass completes with the correct `final_o` 41 cycles after its accept.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared constants and state encoding for the 4-8-1 forward-pass scheduler.
// The weight map puts the 32 hidden weights first and the 8 output weights after them.
package nn_pkg;

  localparam int N_IN      = 4;
  localparam int N_HID     = 8;
  localparam int X_W       = 4;
  localparam int W_W       = 4;
  localparam int H_W       = 10;
  localparam int F_W       = 18;

  localparam int HID_BASE  = 0;
  localparam int OUT_BASE  = 32;
  localparam int LAST_ADDR = 39;

  localparam int A_W       = 6;
  localparam int IW        = $clog2(N_IN);
  localparam int JW        = $clog2(N_HID);
  localparam int REL_W     = IW + JW;

  typedef enum logic [1:0] {
    IDLE,
    HID,
    OUT,
    DRAIN
  } state_t;

endpackage

// File: rtl/fwd_pass_sched_mac.sv
// Time-shared multiply-accumulate unit: one W_W x H_W product per cycle, folded into
// an F_W accumulator that either restarts (first term of a neuron) or keeps adding.
module mac_unit
  import nn_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           i_en,
  input  logic           i_load,
  input  logic [H_W-1:0] i_operand,
  input  logic [W_W-1:0] i_weight,
  output logic [F_W-1:0] o_sum
);

  logic [H_W+W_W-1:0] w_prod;
  logic [F_W-1:0]     r_acc;

  assign w_prod = (H_W+W_W)'(i_operand) * (H_W+W_W)'(i_weight);

  // o_sum is the value the accumulator is about to take, so the caller can
  // capture a finished dot product on the same edge as the last term.
  assign o_sum = i_load ? F_W'(w_prod) : r_acc + F_W'(w_prod);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= o_sum;
    end
  end

endmodule

// File: rtl/fwd_pass_sched.sv
// Forward-pass scheduler: walks the weight ROM once per pass, feeds one MAC with
// inputs (hidden phase) then hidden activations (output phase), and publishes the result.
module fwd_pass_sched
  import nn_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [N_IN*X_W-1:0] x_i,
  output logic                w_rd_o,
  output logic [A_W-1:0]      w_addr_o,
  input  logic [W_W-1:0]      w_data_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [F_W-1:0]      final_o
);

  state_t              r_state;
  state_t              w_state_next;
  logic [A_W-1:0]      r_cnt;
  logic [A_W-1:0]      w_cnt_next;
  logic                w_issue;
  logic                w_accept;

  logic [N_IN*X_W-1:0] r_x;
  logic [H_W-1:0]      r_h [N_HID];

  logic                r_tag_valid;
  logic                r_tag_out;
  logic [A_W-1:0]      r_tag_idx;

  logic [REL_W-1:0]    w_rel;
  logic [IW-1:0]       w_i;
  logic [JW-1:0]       w_j;
  logic [JW-1:0]       w_k;
  logic                w_first;
  logic                w_last;
  logic [H_W-1:0]      w_operand;
  logic [F_W-1:0]      w_sum;
  logic                w_h_we;
  logic                w_fin;

  logic                r_done;
  logic [F_W-1:0]      r_final;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_issue      = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_accept     = 1'b1;
          w_cnt_next   = A_W'(HID_BASE);
          w_state_next = HID;
        end
      end
      HID: begin
        w_issue    = 1'b1;
        w_cnt_next = r_cnt + 1'b1;
        if (r_cnt == A_W'(OUT_BASE - 1)) begin
          w_state_next = OUT;
        end
      end
      OUT: begin
        w_issue = 1'b1;
        if (r_cnt == A_W'(LAST_ADDR)) begin
          w_state_next = DRAIN;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (w_fin) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign w_rd_o   = w_issue;
  assign w_addr_o = w_issue ? r_cnt : '0;
  assign busy_o   = (r_state != IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_x <= '0;
    end else if (w_accept) begin
      r_x <= x_i;
    end
  end

  // The tag lines up with the ROM's one-cycle read latency.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tag_valid <= 1'b0;
      r_tag_out   <= 1'b0;
      r_tag_idx   <= '0;
    end else begin
      r_tag_valid <= w_issue;
      r_tag_out   <= (r_state == OUT);
      r_tag_idx   <= r_cnt;
    end
  end

  assign w_rel     = REL_W'(r_tag_idx - (r_tag_out ? A_W'(OUT_BASE) : A_W'(HID_BASE)));
  assign w_i       = w_rel[IW-1:0];
  assign w_k       = w_rel[REL_W-1:IW];
  assign w_j       = w_rel[JW-1:0];
  assign w_first   = r_tag_out ? (w_j == '0) : (w_i == '0);
  assign w_last    = r_tag_out ? (w_j == JW'(N_HID - 1)) : (w_i == IW'(N_IN - 1));
  assign w_operand = r_tag_out ? r_h[w_j] : H_W'(r_x[w_i*X_W +: X_W]);
  assign w_h_we    = r_tag_valid & ~r_tag_out & w_last;
  assign w_fin     = r_tag_valid & r_tag_out & w_last;

  mac_unit u_mac (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_en      (r_tag_valid),
    .i_load    (w_first),
    .i_operand (w_operand),
    .i_weight  (w_data_i),
    .o_sum     (w_sum)
  );

  // Hidden sums never exceed 900, so the low H_W bits are the whole value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < N_HID; k++) begin
        r_h[k] <= '0;
      end
    end else if (w_h_we) begin
      r_h[w_k] <= w_sum[H_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_done  <= 1'b0;
      r_final <= '0;
    end else begin
      r_done <= w_fin;
      if (w_fin) begin
        r_final <= w_sum;
      end
    end
  end

  assign done_o  = r_done;
  assign final_o = r_final;

endmodule

// File: tb/tb_fwd_pass_sched.sv
// Directed-plus-random bench for fwd_pass_sched: a ROM model answers reads and a
// dot-product reference predicts every result and the per-cycle strobe pattern.
module tb_fwd_pass_sched;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [15:0] x_i;
  logic        w_rd_o;
  logic [5:0]  w_addr_o;
  logic [3:0]  w_data_i = 4'd0;
  logic        busy_o;
  logic        done_o;
  logic [17:0] final_o;

  logic [3:0]  rom [40];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;

  always #5 clk_i = ~clk_i;

  fwd_pass_sched dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .x_i      (x_i),
    .w_rd_o   (w_rd_o),
    .w_addr_o (w_addr_o),
    .w_data_i (w_data_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .final_o  (final_o)
  );

  always @(posedge clk_i) begin
    if (w_rd_o) w_data_i <= rom[w_addr_o];
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Network output straight from the math: h[k] = x . w_k, y = h . w_out.
  function automatic int golden(input logic [15:0] xv);
    int h;
    int f;
    f = 0;
    for (int k = 0; k < 8; k++) begin
      h = 0;
      for (int i = 0; i < 4; i++) h += int'(xv[i*4 +: 4]) * int'(rom[k*4 + i]);
      f += (h % 1024) * int'(rom[32 + k]);
    end
    return f;
  endfunction

  // Accepts a pass (or npasses back-to-back with start held) and checks every cycle
  // against the 42-cycle pass timeline. mess perturbs x and pulses start mid-pass.
  task automatic run_seq(input int npasses, input bit mess, input logic [15:0] xv);
    int  exp_final;
    int  last_n;
    int  p;
    int  k;
    bit  act;
    int  rd_cnt;
    int  done_cnt;
    exp_final = golden(xv);
    last_n    = 42 * npasses;
    rd_cnt    = 0;
    done_cnt  = 0;
    x_i       = xv;
    start_i   = 1'b1;
    tick();
    for (int n = 0; n <= last_n; n++) begin
      if (n > 0) tick();
      p   = n % 42;
      k   = n / 42;
      act = (k < npasses);
      chk($sformatf("rd@%0d", n), w_rd_o, act && p < 40);
      chk($sformatf("addr@%0d", n), w_addr_o, (act && p < 40) ? p : 0);
      chk($sformatf("busy@%0d", n), busy_o, act && p <= 40);
      chk($sformatf("done@%0d", n), done_o, act && p == 41);
      if (act && p == 41) chk($sformatf("final@%0d", n), final_o, exp_final);
      if (w_rd_o === 1'b1) rd_cnt++;
      if (done_o === 1'b1) done_cnt++;
      if (n == 42 * (npasses - 1)) start_i = 1'b0;
      if (mess && n == 5) x_i = ~xv;
      if (mess && n == 9) start_i = 1'b1;
      if (mess && n == 10) start_i = 1'b0;
    end
    chk("final_held", final_o, exp_final);
    chk("rd_cycles", rd_cnt, 40 * npasses);
    chk("done_pulses", done_cnt, npasses);
    $display("pass x=%h passes=%0d mess=%0d final=%0d expected=%0d", xv, npasses, mess, final_o, exp_final);
  endtask

  initial begin
    int   seen;
    logic [15:0] xr;
    rst_i   = 1'b1;
    start_i = 1'b0;
    x_i     = '0;
    for (int a = 0; a < 40; a++) rom[a] = 4'd1;
    repeat (3) tick();
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_rd", w_rd_o, 0);
    chk("rst_addr", w_addr_o, 0);
    chk("rst_final", final_o, 0);
    rst_i = 1'b0;
    tick();
    chk("idle_busy", busy_o, 0);

    run_seq(1, 1'b0, 16'h4321);
    chk("ones_final", final_o, 80);

    for (int a = 0; a < 40; a++) rom[a] = 4'd15;
    run_seq(1, 1'b0, 16'hFFFF);
    chk("max_final", final_o, 108000);

    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < 40; a++) rom[a] = 4'($urandom_range(0, 15));
      run_seq(1, 1'b0, 16'($urandom));
    end

    run_seq(3, 1'b0, 16'($urandom));
    run_seq(1, 1'b1, 16'($urandom));

    // Reset mid-pass, with start also high at the reset edge.
    xr      = 16'($urandom);
    x_i     = xr;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (19) tick();
    rst_i   = 1'b1;
    start_i = 1'b1;
    tick();
    chk("midrst_busy", busy_o, 0);
    chk("midrst_done", done_o, 0);
    chk("midrst_rd", w_rd_o, 0);
    chk("midrst_addr", w_addr_o, 0);
    chk("midrst_final", final_o, 0);
    rst_i   = 1'b0;
    start_i = 1'b0;
    seen    = 0;
    repeat (45) begin
      tick();
      if (done_o !== 1'b0) seen++;
    end
    chk("aborted_done", seen, 0);
    chk("aborted_busy", busy_o, 0);
    chk("aborted_final", final_o, 0);
    run_seq(1, 1'b0, xr);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
